// File: rtl/key_pio_ctrl_pkg.sv
// rtl/key_pio_ctrl_pkg.sv - shared constants, FSM states and event type for the key PIO controller
// KEY_PIO_CTRL_DEBOUNCE_EN adds the HOLD state to the FSM enum.
package key_pio_ctrl_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    localparam int unsigned KEY_W_MAX = 32;

    typedef enum logic [3:0] {
        INIT,
        IDLE,
        RD_EDGE,
        LAT_EDGE,
        CLR_EDGE,
        RD_DATA,
        LAT_DATA,
        PUSH
`ifdef KEY_PIO_CTRL_DEBOUNCE_EN
        , HOLD
`endif
    } state_t;

    // Field names avoid the reserved word "edge".
    typedef struct packed {
        logic [KEY_W_MAX-1:0] edges;
        logic [KEY_W_MAX-1:0] levels;
    } key_evt_t;

    function automatic logic [31:0] key_mask_word(input int unsigned key_w);
        key_mask_word = (key_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << key_w) - 32'd1);
    endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// rtl/key_evt_fifo.sv - event FIFO with wrap-bit pointers, full/empty and a drop strobe
module key_evt_fifo #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             drop_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign drop_o  = push_i & full_o & ~do_pop;

    assign dout_o  = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (do_pop) begin
            rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/key_pio_ctrl.sv
// rtl/key_pio_ctrl.sv - key PIO interrupt service FSM and bus master feeding an event FIFO
// Define KEY_PIO_CTRL_DEBOUNCE_EN to add a post-event hold-off of HOLD_CYC cycles.
module key_pio_ctrl
    import key_pio_ctrl_pkg::*;
#(
    parameter int unsigned KEY_W      = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned HOLD_CYC   = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              irq,
    output logic [1:0]        m_address,
    output logic              m_chipselect,
    output logic              m_write_n,
    output logic [31:0]       m_writedata,
    input  logic [31:0]       m_readdata,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [KEY_W-1:0]  evt_edge,
    output logic [KEY_W-1:0]  evt_level,
    output logic              overflow,
    input  logic              ovf_clr,
    output logic              busy
);

    state_t           state_q, state_d;
    logic [KEY_W-1:0] edge_q, edge_d;
    logic [KEY_W-1:0] lvl_q, lvl_d;
    logic             ovf_q, ovf_d;

    logic             push_c;
    logic             cs_c;
    logic             write_n_c;
    logic [1:0]       addr_c;
    logic [31:0]      wdata_c;

    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_drop;
    logic [2*KEY_W-1:0] fifo_dout;

`ifdef KEY_PIO_CTRL_DEBOUNCE_EN
    localparam int unsigned HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);

    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              from_hold_q, from_hold_d;
`endif

    always_comb begin
        state_d   = state_q;
        edge_d    = edge_q;
        lvl_d     = lvl_q;
        push_c    = 1'b0;
        cs_c      = 1'b0;
        write_n_c = 1'b1;
        addr_c    = ADDR_DATA;
        wdata_c   = '0;
`ifdef KEY_PIO_CTRL_DEBOUNCE_EN
        hold_cnt_d  = hold_cnt_q;
        from_hold_d = from_hold_q;
`endif
        case (state_q)
            INIT: begin
                cs_c      = 1'b1;
                write_n_c = 1'b0;
                addr_c    = ADDR_MASK;
                wdata_c   = key_mask_word(KEY_W);
                state_d   = IDLE;
            end
            IDLE: begin
                if (irq) begin
                    state_d = RD_EDGE;
                end
            end
            RD_EDGE: begin
                cs_c    = 1'b1;
                addr_c  = ADDR_EDGE;
                state_d = LAT_EDGE;
            end
            LAT_EDGE: begin
                edge_d  = m_readdata[KEY_W-1:0];
                state_d = CLR_EDGE;
            end
            CLR_EDGE: begin
                cs_c      = 1'b1;
                write_n_c = 1'b0;
                addr_c    = ADDR_EDGE;
                state_d   = RD_DATA;
`ifdef KEY_PIO_CTRL_DEBOUNCE_EN
                // The clear that closes a hold-off discards bounce edges and ends the service.
                if (from_hold_q) begin
                    from_hold_d = 1'b0;
                    state_d     = IDLE;
                end
`endif
            end
            RD_DATA: begin
                cs_c    = 1'b1;
                addr_c  = ADDR_DATA;
                state_d = LAT_DATA;
            end
            LAT_DATA: begin
                lvl_d   = m_readdata[KEY_W-1:0];
                state_d = PUSH;
            end
            PUSH: begin
                push_c = (edge_q != '0);
`ifdef KEY_PIO_CTRL_DEBOUNCE_EN
                state_d = HOLD;
`else
                state_d = IDLE;
`endif
            end
`ifdef KEY_PIO_CTRL_DEBOUNCE_EN
            HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    hold_cnt_d  = '0;
                    from_hold_d = 1'b1;
                    state_d     = CLR_EDGE;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
`endif
            default: begin
                state_d = INIT;
            end
        endcase
    end

    // Drops set the flag even when a clear is requested in the same cycle.
    always_comb begin
        ovf_d = ovf_q;
        if (fifo_drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= INIT;
            edge_q  <= '0;
            lvl_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            edge_q  <= edge_d;
            lvl_q   <= lvl_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef KEY_PIO_CTRL_DEBOUNCE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt_q  <= '0;
            from_hold_q <= 1'b0;
        end else begin
            hold_cnt_q  <= hold_cnt_d;
            from_hold_q <= from_hold_d;
        end
    end
`endif

    // Bus outputs are decoded from state, so reset masks them to keep INIT from writing while held.
    assign m_chipselect = cs_c & ~reset;
    assign m_write_n    = write_n_c | reset;
    assign m_address    = reset ? 2'd0 : addr_c;
    assign m_writedata  = reset ? 32'd0 : wdata_c;

    key_evt_fifo #(
        .WIDTH (2*KEY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (reset),
        .push_i  (push_c),
        .din_i   ({edge_q, lvl_q}),
        .pop_i   (evt_ready),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .drop_o  (fifo_drop)
    );

    assign evt_valid = ~fifo_empty;
    assign evt_edge  = fifo_dout[2*KEY_W-1:KEY_W];
    assign evt_level = fifo_dout[KEY_W-1:0];
    assign overflow  = ovf_q;
    assign busy      = (state_q != IDLE);

endmodule
